// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down-counter: load a preset, start, decrement once per tick,
// and pulse done on expiry. Optional auto-reload makes it a periodic interval source.
module bcd_dec_digit (
  input  logic [3:0] d,
  input  logic       bin,
  output logic [3:0] q,
  output logic       bout
);
  always_comb begin
    bout = bin && (d == 4'd0);
    if (!bin)           q = d;
    else if (d == 4'd0) q = 4'd9;
    else                q = d - 4'd1;
  end
endmodule

module bcd_down_timer #(
  parameter int DIGITS      = 2,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  load_err
);
  localparam int W = 4*DIGITS;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      preset, count_dec, count_nxt, preset_nxt;
  logic [DIGITS:0]   borrow;
  logic [DIGITS-1:0] digit_ok;
  logic              load_ok, is_zero, is_one, expire, reload, done_nxt, err_nxt;

  // Borrow ripples up from digit 0, which always decrements.
  assign borrow[0] = 1'b1;
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_dec_digit u_dig (
        .d    (count[4*g +: 4]),
        .bin  (borrow[g]),
        .q    (count_dec[4*g +: 4]),
        .bout (borrow[g+1])
      );
      assign digit_ok[g] = (load_val[4*g +: 4] <= 4'd9);
    end
  endgenerate

  assign load_ok = &digit_ok;
  assign is_zero = (count == '0);
  assign is_one  = (count == W'(1));
  assign reload  = (AUTO_RELOAD != 0) && (preset != '0);
  // Expiry only when no higher-priority load/stop claims the cycle.
  assign expire  = (state == RUN) && tick && is_one && !load && !stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load) begin
      if (load_ok) state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (!stop && start && !is_zero) state_nxt = RUN;
        RUN:  if (stop || (expire && !reload)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    count_nxt  = count;
    preset_nxt = preset;
    err_nxt    = 1'b0;
    done_nxt   = expire;
    if (load) begin
      if (load_ok) begin
        count_nxt  = load_val;
        preset_nxt = load_val;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (state == RUN && !stop && tick) begin
      count_nxt = is_one ? (reload ? preset : '0) : count_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      preset   <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      preset   <= preset_nxt;
      done     <= done_nxt;
      load_err <= err_nxt;
    end
  end

  assign running = (state == RUN);
endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: 2-digit stop-at-zero, 2-digit auto-reload
// and 3-digit instances share control inputs; each test checks the relevant one.
module tb_bcd_down_timer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic load = 0, start = 0, stop = 0, tick = 0;
  logic [7:0]  lv2 = '0;
  logic [11:0] lv3 = '0;
  logic [7:0]  c2, ca;
  logic [11:0] c3;
  logic r2, d2, e2, ra, da, ea, r3, d3, e3;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(lv2), .start(start), .stop(stop),
    .tick(tick), .count(c2), .running(r2), .done(d2), .load_err(e2));
  bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(1)) u_ar (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(lv2), .start(start), .stop(stop),
    .tick(tick), .count(ca), .running(ra), .done(da), .load_err(ea));
  bcd_down_timer #(.DIGITS(3), .AUTO_RELOAD(0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(lv3), .start(start), .stop(stop),
    .tick(tick), .count(c3), .running(r3), .done(d3), .load_err(e3));

  // Apply one cycle of control inputs; returns 1 time unit after the edge.
  task automatic drive(input logic l, input logic s, input logic p, input logic t);
    load = l; start = s; stop = p; tick = t;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (c2 !== 8'h00 || r2 !== 1'b0 || d2 !== 1'b0 || e2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: count=%h running=%b done=%b err=%b, want 00 0 0 0", c2, r2, d2, e2);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_run;
    lv2 = 8'h25;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
    checks++;
    if (c2 !== 8'h22 || r2 !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: count=%h running=%b, want 22 1", c2, r2);
    end
    tick = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (c2 !== 8'h00 || r2 !== 1'b0 || d2 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: count=%h running=%b done=%b, want 00 0 0", c2, r2, d2);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_borrow_expiry;
    int v;
    logic [7:0] exp;
    lv2 = 8'h12;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      drive(0, 0, 0, 1);
      v = 12 - k;
      exp = 8'((v / 10) * 16 + (v % 10));
      checks++;
      if (c2 !== exp || d2 !== (k == 12)) begin
        failures++;
        $display("FAIL countdown[%0d]: count=%h done=%b, want %h %b", k, c2, d2, exp, (k == 12));
      end
    end
    checks++;
    if (r2 !== 1'b0) begin
      failures++;
      $display("FAIL stop_at_zero: running=%b, want 0", r2);
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 1);
      checks++;
      if (c2 !== 8'h00 || d2 !== 1'b0) begin
        failures++;
        $display("FAIL extra_tick[%0d]: count=%h done=%b, want 00 0", k, c2, d2);
      end
    end
  endtask

  task automatic test_load_priority;
    lv2 = 8'h3A;
    drive(1, 0, 0, 0);
    checks++;
    if (e2 !== 1'b1 || c2 !== 8'h00) begin
      failures++;
      $display("FAIL bad_load: err=%b count=%h, want 1 00", e2, c2);
    end
    drive(0, 0, 0, 0);
    checks++;
    if (e2 !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse: err=%b, want 0", e2);
    end
    lv2 = 8'h05;
    drive(1, 1, 0, 1);
    checks++;
    if (c2 !== 8'h05 || r2 !== 1'b0 || e2 !== 1'b0) begin
      failures++;
      $display("FAIL load_over_start: count=%h running=%b err=%b, want 05 0 0", c2, r2, e2);
    end
    drive(0, 1, 1, 0);
    checks++;
    if (r2 !== 1'b0) begin
      failures++;
      $display("FAIL stop_over_start: running=%b, want 0", r2);
    end
    drive(0, 1, 0, 0);
    checks++;
    if (r2 !== 1'b1) begin
      failures++;
      $display("FAIL start: running=%b, want 1", r2);
    end
    drive(0, 0, 1, 0);
    checks++;
    if (r2 !== 1'b0 || c2 !== 8'h05) begin
      failures++;
      $display("FAIL stop: running=%b count=%h, want 0 05", r2, c2);
    end
  endtask

  task automatic test_pause_resume;
    lv2 = 8'h30;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 1);
    checks++;
    if (c2 !== 8'h30 || r2 !== 1'b1) begin
      failures++;
      $display("FAIL start_tick_ignored: count=%h running=%b, want 30 1", c2, r2);
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
    checks++;
    if (c2 !== 8'h26) begin
      failures++;
      $display("FAIL run4: count=%h, want 26", c2);
    end
    drive(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1);
    checks++;
    if (c2 !== 8'h26 || r2 !== 1'b0) begin
      failures++;
      $display("FAIL paused: count=%h running=%b, want 26 0", c2, r2);
    end
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    checks++;
    if (c2 !== 8'h25 || r2 !== 1'b1) begin
      failures++;
      $display("FAIL resume: count=%h running=%b, want 25 1", c2, r2);
    end
    drive(0, 0, 1, 0);
  endtask

  task automatic test_auto_reload;
    logic [7:0] seq [9] = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03};
    int dones = 0;
    lv2 = 8'h03;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 0, 1);
      if (da === 1'b1) dones++;
      checks++;
      if (ca !== seq[k] || ra !== 1'b1 || da !== (k % 3 == 2)) begin
        failures++;
        $display("FAIL reload[%0d]: count=%h running=%b done=%b, want %h 1 %b",
                 k, ca, ra, da, seq[k], (k % 3 == 2));
      end
    end
    checks++;
    if (dones != 3) begin
      failures++;
      $display("FAIL reload_dones: got %0d, want 3", dones);
    end
    drive(0, 0, 1, 0);
  endtask

  task automatic test_three_digit;
    lv3 = 12'h100;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    checks++;
    if (c3 !== 12'h099 || r3 !== 1'b1) begin
      failures++;
      $display("FAIL d3_borrow: count=%h running=%b, want 099 1", c3, r3);
    end
    lv3 = 12'h000;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 1);
    checks++;
    if (c3 !== 12'h000 || r3 !== 1'b0 || d3 !== 1'b0) begin
      failures++;
      $display("FAIL d3_start_zero: count=%h running=%b done=%b, want 000 0 0", c3, r3, d3);
    end
    drive(0, 1, 0, 0);
    checks++;
    if (r3 !== 1'b0 || d3 !== 1'b0) begin
      failures++;
      $display("FAIL d3_start_zero2: running=%b done=%b, want 0 0", r3, d3);
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_run;
    test_borrow_expiry;
    test_load_priority;
    test_pause_resume;
    test_auto_reload;
    test_three_digit;
    drive(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
